// File: rtl/usr_ctrl_pkg.sv
// Shared types and constants for the universal shift register controller.
// Optional feature macro: USR_CTRL_ROTATE_EN (enables op 11 rotate right).
package usr_ctrl_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROR  = 2'b11
  } op_e;

  // Controller states; StErr is only reachable when rotate is compiled out.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StDone,
    StErr
  } state_e;

  // Datapath mode select encoding.
  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

endpackage

// File: rtl/usr_datapath.sv
// WIDTH-bit universal register: hold, shift right, shift left, parallel load.
// Optional feature macro: USR_CTRL_ROTATE_EN (handled by the controller, not here).
module usr_datapath
  import usr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Register update selected by mode; synchronous clear wins.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_q <= '0;
    end else begin
      case (mode)
        ModeRight: q_q <= {msb_in, q_q[WIDTH-1:1]};
        ModeLeft:  q_q <= {q_q[WIDTH-2:0], lsb_in};
        ModeLoad:  q_q <= par_in;
        default:   q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a universal shift register (load / shr / shl / ror).
// Optional feature macro: USR_CTRL_ROTATE_EN. When undefined, op 11 is accepted
// but rejected with a one-cycle err pulse and no register change.
module usr_shift_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic             err_q;
  logic             busy_q;

  logic [1:0]       mode;
  logic             msb_in;
  logic             lsb_in;
  logic             accept;

  // Ready is forced low while clear is asserted so nothing is accepted in a reset cycle.
  assign cmd_ready = (state_q == StIdle) && !clear;
  assign accept    = cmd_valid && cmd_ready;

  // Controller FSM with captured command fields and registered status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q   <= op_e'(cmd_op);
            cnt_q  <= cmd_count;
            data_q <= cmd_data;
            busy_q <= 1'b1;
            if (cmd_op == OP_LOAD) begin
              state_q <= StLoad;
`ifndef USR_CTRL_ROTATE_EN
            end else if (cmd_op == OP_ROR) begin
              state_q <= StErr;
              err_q   <= 1'b1;
`endif
            end else if (cmd_count == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StLoad: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StShift: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone, StErr: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath steering and serial output, decoded from state, captured op and q.
  always_comb begin
    mode          = ModeHold;
    msb_in        = ser_in;
    lsb_in        = ser_in;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    case (state_q)
      StLoad: mode = ModeLoad;
      StShift: begin
        ser_out_valid = 1'b1;
        case (op_q)
          OP_SHL: begin
            mode    = ModeLeft;
            ser_out = q[WIDTH-1];
          end
          OP_ROR: begin
            mode    = ModeRight;
            msb_in  = q[0];
            ser_out = q[0];
          end
          default: begin
            mode    = ModeRight;
            ser_out = q[0];
          end
        endcase
      end
      default: mode = ModeHold;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  usr_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk   (clk),
    .clear (clear),
    .mode  (mode),
    .par_in(data_q),
    .msb_in(msb_in),
    .lsb_in(lsb_in),
    .q     (q)
  );

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Self-checking bench for usr_shift_ctrl (WIDTH=4, CNT_W=3).
// Honours USR_CTRL_ROTATE_EN for the op 11 expectations.
module tb_usr_shift_ctrl;
  import usr_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk;
  logic          clear;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [W-1:0]  cmd_data;
  logic          ser_in;
  logic          ser_out;
  logic          ser_out_valid;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic [W-1:0]  data;
    logic [7:0]    ser;    // ser_in for step k is ser[k]
    logic [W-1:0]  exp_q;  // final register contents
    logic          hold_valid;
  } vec_t;

  vec_t         vecs[9];
  logic [W-1:0] m_q;       // reference register model
  logic [W-1:0] q_sb[$];   // expected q after each pending update

  usr_shift_ctrl #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_count    (cmd_count),
    .cmd_data     (cmd_data),
    .ser_in       (ser_in),
    .ser_out      (ser_out),
    .ser_out_valid(ser_out_valid),
    .q            (q),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command, drive serial bits, score every update and the handshake timing.
  task automatic do_cmd(input vec_t v, input int idx);
    int  waitc;
    int  iters;
    int  n_done;
    int  n_err;
    int  n_valid;
    int  n_busy;
    int  exp_steps;
    int  exp_busy;
    bit  fin;
    bit  rot_ok;
    bit  exp_err_b;
    logic [W-1:0] nq;
    logic exp_so;
`ifdef USR_CTRL_ROTATE_EN
    rot_ok = 1'b1;
`else
    rot_ok = 1'b0;
`endif
    exp_err_b = (v.op == OP_ROR) && !rot_ok;
    exp_steps = (v.op == OP_LOAD || exp_err_b) ? 0 : int'(v.cnt);
    if (v.op == OP_LOAD)    exp_busy = 2;
    else if (exp_err_b)     exp_busy = 1;
    else                    exp_busy = int'(v.cnt) + 1;

    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!cmd_ready) begin
      check($sformatf("vec%0d ready_timeout", idx), 32'(cmd_ready), 32'd1);
      return;
    end

    cmd_op    = v.op;
    cmd_count = v.cnt;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    @(negedge clk);
    if (!v.hold_valid) cmd_valid = 1'b0;

    iters = 0; n_done = 0; n_err = 0; n_valid = 0; n_busy = 0; fin = 1'b0;
    while (!fin && iters < 40) begin
      if (q_sb.size() > 0) begin
        nq = q_sb.pop_front();
        check($sformatf("vec%0d q_step", idx), 32'(q), 32'(nq));
      end
      if (busy) n_busy++;
      if (done) begin n_done++; fin = 1'b1; end
      if (err)  begin n_err++;  fin = 1'b1; end
      if (ser_out_valid && !fin) begin
        ser_in = v.ser[n_valid];
        exp_so = (v.op == OP_SHL) ? m_q[W-1] : m_q[0];
        check($sformatf("vec%0d ser_out[%0d]", idx, n_valid), 32'(ser_out), 32'(exp_so));
        case (v.op)
          OP_SHR:  m_q = {ser_in, m_q[W-1:1]};
          OP_SHL:  m_q = {m_q[W-2:0], ser_in};
          default: m_q = {m_q[0], m_q[W-1:1]};
        endcase
        q_sb.push_back(m_q);
        n_valid++;
      end
      if (iters == 0 && v.op == OP_LOAD) begin
        m_q = v.data;
        q_sb.push_back(m_q);
      end
      if (fin) cmd_valid = 1'b0;
      iters++;
      if (!fin) @(negedge clk);
    end
    if (!fin) check($sformatf("vec%0d completion_timeout", idx), 32'(fin), 32'd1);

    check($sformatf("vec%0d done_count", idx), 32'(n_done), exp_err_b ? 32'd0 : 32'd1);
    check($sformatf("vec%0d err_count", idx), 32'(n_err), exp_err_b ? 32'd1 : 32'd0);
    check($sformatf("vec%0d shift_cycles", idx), 32'(n_valid), 32'(exp_steps));
    check($sformatf("vec%0d busy_cycles", idx), 32'(n_busy), 32'(exp_busy));
    check($sformatf("vec%0d final_q", idx), 32'(q), 32'(v.exp_q));
    check($sformatf("vec%0d sb_empty", idx), 32'(q_sb.size()), 32'd0);

    @(negedge clk);
    check($sformatf("vec%0d ready_after", idx), 32'(cmd_ready), 32'd1);
    check($sformatf("vec%0d busy_after", idx), 32'(busy), 32'd0);
    check($sformatf("vec%0d done_pulse", idx), 32'(done), 32'd0);
    check($sformatf("vec%0d err_pulse", idx), 32'(err), 32'd0);
  endtask

  initial begin
    vecs[0] = '{op: OP_LOAD, cnt: 3'd0, data: 4'b1011, ser: 8'h00,
                exp_q: 4'b1011, hold_valid: 1'b0};
    vecs[1] = '{op: OP_SHR, cnt: 3'd2, data: 4'b0000, ser: 8'b0000_0001,
                exp_q: 4'b0110, hold_valid: 1'b0};
    vecs[2] = '{op: OP_SHL, cnt: 3'd3, data: 4'b0000, ser: 8'h00,
                exp_q: 4'b0000, hold_valid: 1'b0};
    vecs[3] = '{op: OP_SHR, cnt: 3'd0, data: 4'b0000, ser: 8'hff,
                exp_q: 4'b0000, hold_valid: 1'b1};
    vecs[4] = '{op: OP_LOAD, cnt: 3'd5, data: 4'b1011, ser: 8'h00,
                exp_q: 4'b1011, hold_valid: 1'b0};
`ifdef USR_CTRL_ROTATE_EN
    vecs[5] = '{op: OP_ROR, cnt: 3'd1, data: 4'b0000, ser: 8'h00,
                exp_q: 4'b1101, hold_valid: 1'b0};
`else
    vecs[5] = '{op: OP_ROR, cnt: 3'd1, data: 4'b0000, ser: 8'h00,
                exp_q: 4'b1011, hold_valid: 1'b0};
`endif
    vecs[6] = '{op: OP_SHL, cnt: 3'd7, data: 4'b0000, ser: 8'b0011_0110,
                exp_q: 4'b0110, hold_valid: 1'b0};
    vecs[7] = '{op: OP_SHR, cnt: 3'd5, data: 4'b0000, ser: 8'b0001_0011,
                exp_q: 4'b1001, hold_valid: 1'b0};
    vecs[8] = '{op: OP_LOAD, cnt: 3'd0, data: 4'b1011, ser: 8'h00,
                exp_q: 4'b1011, hold_valid: 1'b0};

    clear     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    cmd_data  = '0;
    ser_in    = 1'b0;
    m_q       = '0;

    // Reset state, sampled while clear is still asserted.
    repeat (2) @(negedge clk);
    check("reset q", 32'(q), 32'd0);
    check("reset ready", 32'(cmd_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset ser_out_valid", 32'(ser_out_valid), 32'd0);
    clear = 1'b0;
    @(negedge clk);
    check("ready after reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) do_cmd(vecs[i], i);

    // Abort a 5-step shift with clear in its second cycle.
    cmd_op    = OP_SHR;
    cmd_count = 3'd5;
    cmd_data  = 4'b0000;
    ser_in    = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort first shift cycle", 32'(ser_out_valid), 32'd1);
    @(negedge clk);
    check("abort second shift cycle", 32'(ser_out_valid), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    check("abort q cleared", 32'(q), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort err", 32'(err), 32'd0);
    check("abort ready during clear", 32'(cmd_ready), 32'd0);
    clear = 1'b0;
    m_q   = '0;
    q_sb.delete();
    @(negedge clk);
    check("abort no late done", 32'(done), 32'd0);
    check("abort ready after", 32'(cmd_ready), 32'd1);

    do_cmd(vecs[8], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
